adc_reader: RTL and testbench

- SPI master receiver that reads one conversion word from an external 12-bit serial ADC (MCP3201-style: CS low, lead/null bits, then data MSB first).
- Receive-side counterpart of the DAC transmit path. Supplies a sampled control voltage (rate/depth CV) to the LFO parameter logic.
- Sits beside the DAC interface on GPIO_0 and runs from CLOCK_50.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/spi_tick_gen.sv | 28 ++
 rtl/adc_reader.sv | 148 ++++++++++++++
 tb/tb_adc_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the serial ADC reader.
// The defaults match an MCP3201-style 12-bit converter with three lead bits.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int DEF_LEAD_BITS  = 3;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int FRAME_BITS     = DEF_LEAD_BITS + DEF_DATA_WIDTH;
  localparam int BIT_CNT_W      = $clog2(FRAME_BITS + 1);

  function automatic int bit_cnt_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for an SPI master clock.
// It emits a one-cycle tick every CLK_DIV clocks; clr restarts the count.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// SPI master that reads one conversion word per frame from a serial ADC.
// The word is clocked in MSB first after the lead and null bits.
module adc_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LEAD_BITS   = DEF_LEAD_BITS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int HOLD_HALVES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic                  ADC_DOUT,
  output logic                  ADC_CSB,
  output logic                  ADC_SCLK,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy,
  output logic                  null_err
);

  localparam int FRAME_LEN = LEAD_BITS + DATA_WIDTH;
  localparam int CNT_W     = bit_cnt_width(FRAME_LEN);
  localparam int HALF_W    = $clog2(HOLD_HALVES + 2);

  state_t                 state, state_nxt;
  logic [FRAME_LEN-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [HALF_W-1:0]      half_cnt, half_nxt;
  logic                   csb_nxt, sclk_nxt, busy_nxt, valid_nxt, null_nxt;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic                   tick;
  logic                   rise;

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );

  // Every cycle that drives SCLK low-to-high also samples the ADC output.
  assign rise = tick && ((state == SETUP) || ((state == SHIFT) && !ADC_SCLK));

  always_comb begin
    state_nxt   = state;
    csb_nxt     = ADC_CSB;
    sclk_nxt    = ADC_SCLK;
    busy_nxt    = busy;
    valid_nxt   = 1'b0;
    data_nxt    = data;
    null_nxt    = null_err;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    half_nxt    = half_cnt;

    unique case (state)
      IDLE: begin
        csb_nxt  = 1'b1;
        sclk_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (start || auto_en) begin
          state_nxt   = SETUP;
          csb_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          half_nxt    = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!ADC_SCLK) begin
            sclk_nxt = 1'b1;
          end else if (bit_cnt != CNT_W'(FRAME_LEN)) begin
            sclk_nxt = 1'b0;
          end else if (half_cnt == '0) begin
            // Last rising edge: keep SCLK high one extra half-period.
            half_nxt = HALF_W'(1);
          end else begin
            state_nxt = HOLD;
            sclk_nxt  = 1'b0;
            csb_nxt   = 1'b1;
            half_nxt  = '0;
            data_nxt  = shreg[DATA_WIDTH-1:0];
            valid_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (half_cnt == HALF_W'(HOLD_HALVES - 1)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            half_nxt  = '0;
          end else begin
            half_nxt = half_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rise) begin
      shreg_nxt   = {shreg[FRAME_LEN-2:0], ADC_DOUT};
      bit_cnt_nxt = bit_cnt + 1'b1;
      if ((bit_cnt == CNT_W'(LEAD_BITS - 1)) && ADC_DOUT) begin
        null_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ADC_CSB  <= 1'b1;
      ADC_SCLK <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
      null_err <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ADC_CSB  <= csb_nxt;
      ADC_SCLK <= sclk_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      data     <= data_nxt;
      null_err <= null_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      half_cnt <= half_nxt;
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Scoreboard bench for adc_reader: ADC models feed words, a monitor checks every valid pulse.
// Two instances cover the default divider and CLK_DIV=2.
module tb_adc_reader;

  localparam int FB    = 15;
  localparam int LAT4  = 4 + (FB - 1) * 8 + 8;
  localparam int BUSY4 = LAT4 + 8;
  localparam int PER4  = BUSY4 + 1;
  localparam int LAT2  = 2 + (FB - 1) * 4 + 4;

  typedef struct {
    logic [11:0] data;
    logic        nerr;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 1'b0, auto_a = 1'b0, dout_a = 1'b0;
  logic        csb_a, sclk_a, valid_a, busy_a, null_err_a;
  logic [11:0] data_a;
  logic        start_b = 1'b0, auto_b = 1'b0, dout_b = 1'b0;
  logic        csb_b, sclk_b, valid_b, busy_b, null_err_b;
  logic [11:0] data_b;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [12:0] mq_a[$];
  logic [12:0] mq_b[$];

  int checks = 0;
  int fails  = 0;
  bit chk_gap = 1'b0;

  adc_reader dut_a (
    .clk(clk), .rst(rst), .start(start_a), .auto_en(auto_a), .ADC_DOUT(dout_a),
    .ADC_CSB(csb_a), .ADC_SCLK(sclk_a), .data(data_a), .valid(valid_a),
    .busy(busy_a), .null_err(null_err_a)
  );

  adc_reader #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .auto_en(auto_b), .ADC_DOUT(dout_b),
    .ADC_CSB(csb_b), .ADC_SCLK(sclk_b), .data(data_b), .valid(valid_b),
    .busy(busy_b), .null_err(null_err_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ADC models: load {00, null, word} on CSB fall, advance on each SCLK fall.
  logic        csb_a_d = 1'b1, sclk_a_d = 1'b0, csb_b_d = 1'b1, sclk_b_d = 1'b0;
  logic [14:0] fr_a = '0, fr_b = '0;
  int          idx_a = 0, idx_b = 0;

  always @(negedge clk) begin
    if (csb_a_d === 1'b1 && csb_a === 1'b0) begin
      if (mq_a.size() > 0) fr_a = {2'b00, mq_a.pop_front()};
      else fr_a = '0;
      idx_a  = 0;
      dout_a = fr_a[14];
    end else if (csb_a === 1'b0 && sclk_a_d === 1'b1 && sclk_a === 1'b0) begin
      idx_a++;
      dout_a = (idx_a < FB) ? fr_a[14-idx_a] : 1'b0;
    end
    csb_a_d  = csb_a;
    sclk_a_d = sclk_a;
  end

  always @(negedge clk) begin
    if (csb_b_d === 1'b1 && csb_b === 1'b0) begin
      if (mq_b.size() > 0) fr_b = {2'b00, mq_b.pop_front()};
      else fr_b = '0;
      idx_b  = 0;
      dout_b = fr_b[14];
    end else if (csb_b === 1'b0 && sclk_b_d === 1'b1 && sclk_b === 1'b0) begin
      idx_b++;
      dout_b = (idx_b < FB) ? fr_b[14-idx_b] : 1'b0;
    end
    csb_b_d  = csb_b;
    sclk_b_d = sclk_b;
  end

  // Monitors: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_a === 1'b1) begin
      if (sb_a.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_valid_a: got valid=1 data=0x%0h, expected valid=0", data_a);
      end else begin
        e = sb_a.pop_front();
        checkOutput("data_a", 32'(data_a), 32'(e.data));
        checkOutput("null_err_a", 32'(null_err_a), 32'(e.nerr));
        checkOutput("valid_cycle_a", cyc, e.cycle);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_valid_b: got valid=1 data=0x%0h, expected valid=0", data_b);
      end else begin
        e = sb_b.pop_front();
        checkOutput("data_b", 32'(data_b), 32'(e.data));
        checkOutput("null_err_b", 32'(null_err_b), 32'(e.nerr));
        checkOutput("valid_cycle_b", cyc, e.cycle);
      end
    end
  end

  // CSB must stay high at least two half-periods between auto frames.
  int  hi_run = 0;
  logic csb_prev = 1'b1;
  always @(negedge clk) begin
    if (csb_a === 1'b1) begin
      hi_run++;
    end else begin
      if (csb_prev === 1'b1 && chk_gap) begin
        checks++;
        if (hi_run < 8) begin
          fails++;
          $display("[TB] FAIL csb_high_gap: got %0d cycles, required at least 8", hi_run);
        end
      end
      hi_run = 0;
    end
    csb_prev = csb_a;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [11:0] word, input logic nbit,
                               input logic exp_nerr, input bit expect_valid,
                               output int e0);
    exp_t e;
    mq_a.push_back({nbit, word});
    e0 = cyc + 1;
    if (expect_valid) begin
      e.data  = word;
      e.nerr  = exp_nerr;
      e.cycle = e0 + LAT4;
      sb_a.push_back(e);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while ((busy_a !== 1'b0 || sb_a.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("[TB] FAIL timeout_a: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic profileFrame(input int e0, output int rises, output int csb_low,
                              output int busy_end);
    logic prev;
    int   n;
    prev = 1'b0; n = 0; rises = 0; csb_low = 0;
    while (busy_a === 1'b1 && n < 400) begin
      if (csb_a === 1'b0) csb_low++;
      if (csb_a === 1'b0 && sclk_a === 1'b1 && !prev) rises++;
      prev = sclk_a;
      @(negedge clk);
      n++;
    end
    busy_end = cyc - e0;
  endtask

  initial begin
    int e0, rises, csb_low, busy_end, n, r1, r2;
    logic prev;
    exp_t e;

    waitCycles(3);
    checkOutput("rst_csb", 32'(csb_a), 32'd1);
    checkOutput("rst_sclk", 32'(sclk_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_data", 32'(data_a), 32'd0);
    checkOutput("rst_null_err", 32'(null_err_a), 32'd0);
    rst = 1'b0;
    waitCycles(2);

    $display("[TB] single read 0xA5C");
    applyStimulus(12'hA5C, 1'b0, 1'b0, 1'b1, e0);
    profileFrame(e0, rises, csb_low, busy_end);
    checkOutput("sclk_rises", rises, 15);
    checkOutput("csb_low_cycles", csb_low, LAT4);
    checkOutput("busy_cycles", busy_end, BUSY4);
    waitDone(50);

    $display("[TB] start while busy");
    applyStimulus(12'h5A3, 1'b0, 1'b0, 1'b1, e0);
    waitCycles(39);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_fall_ignored_start", cyc - e0, BUSY4);
    waitCycles(10);
    checkOutput("no_queued_frame", 32'(busy_a), 32'd0);
    waitDone(50);

    $display("[TB] null bit error");
    applyStimulus(12'h001, 1'b1, 1'b1, 1'b1, e0);
    waitDone(300);
    applyStimulus(12'h7E4, 1'b0, 1'b1, 1'b1, e0);
    waitDone(300);
    checkOutput("null_err_sticky", 32'(null_err_a), 32'd1);

    $display("[TB] auto mode");
    waitCycles(3);
    e0 = cyc + 1;
    mq_a.push_back({1'b0, 12'h000});
    mq_a.push_back({1'b0, 12'hFFF});
    mq_a.push_back({1'b0, 12'h800});
    e.nerr = 1'b1;
    e.data = 12'h000; e.cycle = e0 + LAT4;            sb_a.push_back(e);
    e.data = 12'hFFF; e.cycle = e0 + LAT4 + PER4;     sb_a.push_back(e);
    e.data = 12'h800; e.cycle = e0 + LAT4 + 2 * PER4; sb_a.push_back(e);
    chk_gap = 1'b1;
    auto_a  = 1'b1;
    waitCycles(2 * PER4 + 20);
    auto_a = 1'b0;
    waitDone(300);
    chk_gap = 1'b0;
    waitCycles(20);
    checkOutput("auto_stopped", 32'(busy_a), 32'd0);

    $display("[TB] reset mid-frame");
    mq_a.push_back({1'b0, 12'hABC});
    applyStimulus(12'hABC, 1'b0, 1'b0, 1'b0, e0);
    mq_a.pop_back();
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 7 && n < 200) begin
      if (csb_a === 1'b0 && sclk_a === 1'b1 && !prev) rises++;
      prev = sclk_a;
      if (rises < 7) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("reached_7th_rise", rises, 7);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_csb", 32'(csb_a), 32'd1);
    checkOutput("abort_sclk", 32'(sclk_a), 32'd0);
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_data", 32'(data_a), 32'd0);
    checkOutput("abort_valid", 32'(valid_a), 32'd0);
    checkOutput("abort_null_err", 32'(null_err_a), 32'd0);
    rst = 1'b0;
    waitCycles(2);
    applyStimulus(12'h3C5, 1'b0, 1'b0, 1'b1, e0);
    waitDone(300);

    $display("[TB] CLK_DIV=2 instance");
    mq_b.push_back({1'b0, 12'h123});
    e.data = 12'h123; e.nerr = 1'b0; e.cycle = cyc + 1 + LAT2;
    sb_b.push_back(e);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    rises = 0; prev = 1'b0; n = 0; r1 = 0; r2 = 0;
    while (busy_b === 1'b1 && n < 200) begin
      if (csb_b === 1'b0 && sclk_b === 1'b1 && !prev) begin
        rises++;
        if (rises == 1) r1 = cyc;
        if (rises == 2) r2 = cyc;
      end
      prev = sclk_b;
      @(negedge clk);
      n++;
    end
    checkOutput("sclk_period_b", r2 - r1, 4);
    checkOutput("sclk_rises_b", rises, 15);
    waitCycles(5);

    checkOutput("scoreboard_a_empty", sb_a.size(), 0);
    checkOutput("scoreboard_b_empty", sb_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
